eth_rcr_unpack: RTL
===================

Name: eth_rcr_unpack

Overview:
- Ethernet Rx unpacker: the receive-side counterpart of the Tx packer.
- Consumes 8-bit AXI-Stream frames from the Ethernet client Rx FIFO, laid out as dst MAC(6), src MAC(6), length(2, big-endian), payload, then padding.
- Filters frames on destination address, strips the 14-byte header, and forwards exactly `length` payload bytes to the user interface with `tlast` on the final byte.
- Discards padding and malformed frames, and reports them on status pulses.

Parameters:
- my_addr, 48'h001F293A10FD, station MAC; frame accepted if dst == my_addr.
- accept_bcast, 1'b1, when 1 also accept dst == 48'hFFFFFFFFFFFF.
- max_data_size, 16'd1024, largest legal length field; larger values cause a drop.

Ports:
- i_axi_rx_clk  in  1  sole clock.
- i_axi_rx_rst  in  1  asynchronous, active-high reset.
- i_rx_axis_fifo_tdata  in  8  byte from client Rx FIFO.
- i_rx_axis_fifo_tvalid  in  1  upstream byte valid.
- i_rx_axis_fifo_tlast  in  1  last byte of frame.
- o_rx_axis_fifo_tready  out  1  upstream ready.
- o_axi_rx_tdata  out  8  payload byte to user.
- o_axi_rx_data_tvalid  out  1  payload valid.
- o_axi_rx_data_tlast  out  1  last payload byte of frame.
- i_axi_rx_data_tready  in  1  user ready.
- o_src_addr  out  48  source MAC of the frame currently being delivered.
- o_pkt_len  out  16  length field of the frame currently being delivered.
- o_pkt_drop  out  1  one-cycle pulse: frame discarded.
- o_len_err  out  1  one-cycle pulse: frame ended before `length` payload bytes arrived.

Behaviour:
- Reset (async, i_axi_rx_rst=1): state=HDR, byte counter=0, all outputs 0 (tvalid, tlast, tdata, o_src_addr, o_pkt_len, pulses).
- Upstream beat = i_rx_axis_fifo_tvalid & o_rx_axis_fifo_tready. Downstream beat = o_axi_rx_data_tvalid & i_axi_rx_data_tready.
- Output is a single register stage; data, valid and last are registered.
- Output tvalid holds until its beat; tdata and tlast are stable while tvalid=1 and tready=0.
- o_rx_axis_fifo_tready:
  - 1 in HDR and DROP.
  - In DATA: ~o_axi_rx_data_tvalid | i_axi_rx_data_tready.
- HDR state (byte counter cnt 0..13 counts upstream beats):
  - cnt 0-5: compare against my_addr (or broadcast) into a running match flag.
  - cnt 6-11: shift into a src shadow register.
  - cnt 12: length MSB; cnt 13: length LSB.
  - At the cnt 13 beat:
    - If match, 0 < len <= max_data_size, and tlast=0: load o_src_addr and o_pkt_len, clear the payload counter, go to DATA.
    - Else if tlast=1: pulse o_pkt_drop, stay in HDR with cnt=0.
    - Else: pulse o_pkt_drop, go to DROP.
  - tlast on any header beat with cnt<13 (runt frame): pulse o_pkt_drop, cnt=0, stay in HDR.
- DATA state: each upstream beat loads the output register and increments the payload counter pc (16-bit).
  - Beat with pc+1 == len and tlast=1: output tlast=1, go to HDR.
  - Beat with pc+1 == len and tlast=0: output tlast=1, go to DROP to discard padding/FCS.
  - Beat with pc+1 < len and tlast=1: output tlast=1, pulse o_len_err, go to HDR.
- DROP state: accept and discard bytes; tlast beat returns to HDR with cnt=0. A frame that enters DROP after successful payload delivery (padding) is not counted as a drop.
- Zero-bubble requirement: with tvalid and tready held high on both sides, throughput is 1 payload byte per clock and latency is 1 clock from upstream beat to output valid.
- Header bytes are never forwarded. The next frame's header is parsed while the last payload byte waits in the output register.
- Pulses are exactly one cycle, registered.
- Reset asserted mid-frame: immediate return to reset values. The remainder of the frame in the FIFO is parsed as a new header; deassertion is synchronised by the system.

Test Plan:
- Frame dst=001F293A10FD, src=AABBCCDDEEFF, len=0x0004, payload 11 22 33 44, tlast on 44, both readies high -> user sees 11,22,33,44 on 4 consecutive cycles, tlast with 44, o_pkt_len=4, o_src_addr=AABBCCDDEEFF, no pulses.
- Frame len=0x0003, payload 01 02 03 followed by 43 pad bytes, tlast on the last pad -> user sees 01 02 03 with tlast on 03; pad bytes never appear; no o_pkt_drop.
- Frame dst=001122334455, len=8 -> no user output, one o_pkt_drop pulse; an immediately following valid frame is delivered intact.
- len=0x0401 (1025) or len=0 -> o_pkt_drop pulse, no output; frame of len=1024 -> 1024 bytes with tlast on the 1024th.
- len=6 but upstream tlast after 4 payload bytes -> 4 bytes out, tlast on the 4th, one o_len_err pulse; 8-byte runt frame -> o_pkt_drop, no output.
- Random i_axi_rx_data_tready toggling on a 64-byte broadcast frame -> all 64 bytes in order, none lost or duplicated, output held stable while stalled; async reset mid-payload -> tvalid drops to 0 the same cycle, and the next full frame is delivered correctly.

Source files
------------

// File: rtl/eth_rcr_unpack.sv
`timescale 1ns/1ps
// Ethernet Rx unpacker: filters frames on destination MAC, strips the 14-byte
// header and forwards exactly `length` payload bytes with tlast on the last one.
module eth_rcr_unpack #(
  parameter logic [47:0] my_addr       = 48'h001F293A10FD,
  parameter bit          accept_bcast  = 1'b1,
  parameter logic [15:0] max_data_size = 16'd1024
) (
  input  logic        i_axi_rx_clk,
  input  logic        i_axi_rx_rst,
  input  logic [7:0]  i_rx_axis_fifo_tdata,
  input  logic        i_rx_axis_fifo_tvalid,
  input  logic        i_rx_axis_fifo_tlast,
  output logic        o_rx_axis_fifo_tready,
  output logic [7:0]  o_axi_rx_tdata,
  output logic        o_axi_rx_data_tvalid,
  output logic        o_axi_rx_data_tlast,
  input  logic        i_axi_rx_data_tready,
  output logic [47:0] o_src_addr,
  output logic [15:0] o_pkt_len,
  output logic        o_pkt_drop,
  output logic        o_len_err
);
  typedef enum logic [1:0] {HDR, DATA, DROP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic [103:0]  hdr_sr;   // header bytes 0..12, byte 0 in the top lane
  logic [15:0]   pc, pc_inc;
  logic [47:0]   hdr_dst, hdr_src;
  logic [15:0]   hdr_len;
  logic          up_beat, dn_beat, hdr_done, hdr_ok, runt, pay_end;

  assign up_beat  = i_rx_axis_fifo_tvalid & o_rx_axis_fifo_tready;
  assign dn_beat  = o_axi_rx_data_tvalid & i_axi_rx_data_tready;
  assign hdr_dst  = hdr_sr[103:56];
  assign hdr_src  = hdr_sr[55:8];
  assign hdr_len  = {hdr_sr[7:0], i_rx_axis_fifo_tdata};
  assign hdr_done = up_beat && (state == HDR) && (cnt == 4'd13);
  assign hdr_ok   = ((hdr_dst == my_addr) || (accept_bcast && (hdr_dst == {48{1'b1}}))) &&
                    (hdr_len != 16'd0) && (hdr_len <= max_data_size) && !i_rx_axis_fifo_tlast;
  assign runt     = up_beat && (state == HDR) && (cnt != 4'd13) && i_rx_axis_fifo_tlast;
  assign pc_inc   = pc + 16'd1;
  assign pay_end  = (pc_inc == o_pkt_len);

  always_ff @(posedge i_axi_rx_clk or posedge i_axi_rx_rst)
    if (i_axi_rx_rst) state <= HDR;
    else              state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      HDR:  if (hdr_done) state_nxt = hdr_ok ? DATA : (i_rx_axis_fifo_tlast ? HDR : DROP);
      DATA: if (up_beat) begin
              if (pay_end)                   state_nxt = i_rx_axis_fifo_tlast ? HDR : DROP;
              else if (i_rx_axis_fifo_tlast) state_nxt = HDR;
            end
      DROP: if (up_beat && i_rx_axis_fifo_tlast) state_nxt = HDR;
      default: state_nxt = HDR;
    endcase
  end

  // Header/drop bytes never touch the output register, so upstream only
  // waits on the user while payload is flowing.
  always_comb
    o_rx_axis_fifo_tready = (state != DATA) || !o_axi_rx_data_tvalid || i_axi_rx_data_tready;

  always_ff @(posedge i_axi_rx_clk or posedge i_axi_rx_rst) begin
    if (i_axi_rx_rst) begin
      cnt                  <= '0;
      hdr_sr               <= '0;
      pc                   <= '0;
      o_axi_rx_tdata       <= '0;
      o_axi_rx_data_tvalid <= 1'b0;
      o_axi_rx_data_tlast  <= 1'b0;
      o_src_addr           <= '0;
      o_pkt_len            <= '0;
      o_pkt_drop           <= 1'b0;
      o_len_err            <= 1'b0;
    end else begin
      o_pkt_drop <= runt || (hdr_done && !hdr_ok);
      o_len_err  <= (state == DATA) && up_beat && !pay_end && i_rx_axis_fifo_tlast;

      if ((state == HDR) && up_beat) begin
        cnt    <= (i_rx_axis_fifo_tlast || (cnt == 4'd13)) ? 4'd0 : cnt + 4'd1;
        hdr_sr <= {hdr_sr[95:0], i_rx_axis_fifo_tdata};
      end

      if (hdr_done && hdr_ok) begin
        o_src_addr <= hdr_src;
        o_pkt_len  <= hdr_len;
        pc         <= '0;
      end

      if ((state == DATA) && up_beat) begin
        o_axi_rx_tdata       <= i_rx_axis_fifo_tdata;
        o_axi_rx_data_tvalid <= 1'b1;
        o_axi_rx_data_tlast  <= pay_end || i_rx_axis_fifo_tlast;
        pc                   <= pc_inc;
      end else if (dn_beat) begin
        o_axi_rx_data_tvalid <= 1'b0;
      end
    end
  end
endmodule
